progmem_arbiter: RTL and testbench
==================================

Name: progmem_arbiter

Overview:
- Shares the single-port program/data memory between two requesters: the instruction-fetch unit (read-only) and the load/store unit (read or byte-masked write).
- Sits between the core and the memory. It drives the memory's addr, data_in, rd_strobe and wr_strobe inputs and routes its registered data_out back to the requester that issued the read.
- Uses fixed priority to the load/store unit, with a starvation guard for fetch.
- Sustains one access per cycle, pipelined.

Parameters:
- ADDR_W, 32, byte-address width on all ports.
- MAX_STREAK, 4, maximum number of consecutive load/store grants while fetch is waiting; the next grant is forced to fetch. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch byte address
- if_ready  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  32  fetch read data
- ls_req  in  1  load/store request
- ls_addr  in  ADDR_W  load/store byte address
- ls_wdata  in  32  store data
- ls_wmask  in  4  byte-write mask; 0 means read
- ls_ready  out  1  load/store request accepted this cycle
- ls_rvalid  out  1  load data valid
- ls_rdata  out  32  load data
- mem_addr  out  ADDR_W  to memory addr
- mem_wdata  out  32  to memory data_in
- mem_rd  out  1  to memory rd_strobe
- mem_wr  out  4  to memory wr_strobe
- mem_rdata  in  32  from memory data_out; valid the cycle after mem_rd

Behaviour:
- **Grant (combinational, each cycle):**
  - If only one requester is active, it wins.
  - If both are active, ls wins, unless streak == MAX_STREAK, in which case if wins.
  - The winner's ready is high. The loser's ready is low, and it must hold req and its address/data stable until ready.
- **Memory drive (combinational from the winner):**
  - mem_addr = winner addr.
  - Fetch winner: mem_rd=1, mem_wr=0.
  - ls read winner (wmask==0): mem_rd=1, mem_wr=0.
  - ls write winner: mem_rd=0, mem_wr=ls_wmask, mem_wdata=ls_wdata.
  - No winner: mem_rd=0, mem_wr=0; mem_addr and mem_wdata don't-care (implementation holds 0).
- **Streak counter:**
  - Increments on an ls grant while if_req is high (saturating at MAX_STREAK).
  - Clears on any if grant, or on any cycle where if_req is low.
- **Read return (pipelined, 1-cycle latency):**
  - Registered state: rd_pending (1 bit) and rd_owner (IF or LS), captured on every read grant.
  - Cycle N+1 after a read grant: owner's rvalid=1 and owner's rdata = mem_rdata; the other rvalid=0.
  - A new grant may issue in the same cycle N+1, so back-to-back reads give one rvalid per cycle.
  - Responses cannot be backpressured.
- **Writes:**
  - Complete at the grant edge.
  - No rvalid, and rd_pending is cleared.
  - Write followed next cycle by a read of the same word returns the new data (the memory ordering guarantees this).
- **rdata outputs:**
  - Both rdata outputs are driven from mem_rdata.
  - rdata is meaningful only while the corresponding rvalid is high.
- **States:** IDLE (rd_pending=0) and RD_RET (rd_pending=1).
  - IDLE -> RD_RET on a read grant.
  - RD_RET -> RD_RET on a read grant.
  - RD_RET -> IDLE on a write grant or no grant.
  - IDLE stays in IDLE on a write grant or no grant.
- **Reset:**
  - Async assertion: rd_pending=0, rd_owner=IF, streak=0.
  - All ready/rvalid/mem_rd/mem_wr are 0 while rst is low; these outputs are gated by rst.
  - A read in flight at reset is dropped and produces no rvalid.
- **Alignment:** addresses pass through unmodified; the memory ignores addr[1:0].

Decomposition:
- Shared package: owner encoding (OWN_IF=0, OWN_LS=1), the 4-bit byte-mask width constant, and the memory read latency constant (1).
- Natural sub-module: `prio_starve_sel`, containing the priority select and streak counter. It outputs the grant vector; the top holds the mem mux and return pipeline.

Test Plan:
- **Single fetch:** if_req=1 with if_addr=0x10, memory word 4 = 0xDEADBEEF -> if_ready=1 same cycle, mem_rd=1, mem_addr=0x10; next cycle if_rvalid=1, if_rdata=0xDEADBEEF, ls_rvalid=0.
- **Contention:** if_req and ls_req held high, ls reads with MAX_STREAK=4 -> ls granted 4 consecutive cycles, if granted on the 5th, then ls again; rvalids follow grants by exactly 1 cycle with the correct owner.
- **Byte write then read-back:** ls write to 0x20, wmask=4'b0101, wdata=0x11223344, over old word 0xAABBCCDD -> mem_wr=4'b0101, no rvalid; next-cycle ls read of 0x20 -> ls_rvalid with 0xAA22CC44.
- **Back-to-back interleave:** fetch 0x0, ls read 0x4, fetch 0x8 on consecutive cycles -> rvalid sequence IF, LS, IF on consecutive cycles with the matching words.
- **Reset mid-read:** read granted, then rst driven low before the next edge -> no rvalid after reset; all outputs 0 while rst is low; first grant after release behaves as from IDLE with streak=0.
- **Idle and write-only:** no requests -> mem_rd=0, mem_wr=0, readies 0; a store while if_req=0 leaves streak at 0.

Source files
------------

// File: rtl/progmem_arbiter_pkg.sv
// Shared types and constants for the program/data memory arbiter.
package progmem_arbiter_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned MASK_W     = 4;
  localparam int unsigned RD_LATENCY = 1;
  localparam int unsigned STREAK_W   = 4;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  typedef enum logic {
    IDLE   = 1'b0,
    RD_RET = 1'b1
  } ret_state_e;

  typedef struct packed {
    logic gnt_if;
    logic gnt_ls;
  } grant_t;

endpackage

// File: rtl/prio_starve_sel.sv
// Fixed-priority select favouring load/store, with a streak counter that
// forces a fetch grant after MAX_STREAK consecutive load/store wins.
module prio_starve_sel
  import progmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   if_req,
  input  logic   ls_req,
  output grant_t gnt_c
);

  logic [STREAK_W-1:0] streak;
  logic                streak_full;

  assign streak_full = (streak == STREAK_W'(MAX_STREAK));

  always_comb begin
    gnt_c = '0;
    if (if_req && (!ls_req || streak_full)) begin
      gnt_c.gnt_if = 1'b1;
    end else if (ls_req) begin
      gnt_c.gnt_ls = 1'b1;
    end
  end

  // Counts load/store wins only while fetch is actually waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      streak <= '0;
    end else if (!if_req || gnt_c.gnt_if) begin
      streak <= '0;
    end else if (gnt_c.gnt_ls && !streak_full) begin
      streak <= streak + STREAK_W'(1);
    end
  end

endmodule

// File: rtl/progmem_arbiter.sv
// Shares the single-port program/data memory between instruction fetch and
// load/store; one access per cycle with registered read-return routing.
module progmem_arbiter
  import progmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [MASK_W-1:0] ls_wmask,
  output logic              ls_ready,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic [MASK_W-1:0] mem_wr,
  input  logic [DATA_W-1:0] mem_rdata
);

  grant_t     gnt_raw;
  logic       gnt_if;
  logic       gnt_ls;
  logic       ls_is_write;
  logic       rd_grant;
  ret_state_e state;
  owner_e     rd_owner;

  prio_starve_sel #(
    .MAX_STREAK (MAX_STREAK)
  ) u_sel (
    .clk    (clk),
    .rst    (rst),
    .if_req (if_req),
    .ls_req (ls_req),
    .gnt_c  (gnt_raw)
  );

  // Grants are forced low while reset is held so nothing reaches the memory.
  assign gnt_if      = rst & gnt_raw.gnt_if;
  assign gnt_ls      = rst & gnt_raw.gnt_ls;
  assign ls_is_write = |ls_wmask;
  assign rd_grant    = gnt_raw.gnt_if | (gnt_raw.gnt_ls & ~ls_is_write);

  assign if_ready = gnt_if;
  assign ls_ready = gnt_ls;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd    = 1'b0;
    mem_wr    = '0;
    if (gnt_if) begin
      mem_addr = if_addr;
      mem_rd   = 1'b1;
    end else if (gnt_ls) begin
      mem_addr = ls_addr;
      if (ls_is_write) begin
        mem_wdata = ls_wdata;
        mem_wr    = ls_wmask;
      end else begin
        mem_rd = 1'b1;
      end
    end
  end

  // Return tracker: remembers who issued last cycle's read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rd_owner <= OWN_IF;
    end else begin
      case (state)
        IDLE, RD_RET: begin
          if (rd_grant) begin
            state    <= RD_RET;
            rd_owner <= gnt_raw.gnt_ls ? OWN_LS : OWN_IF;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign if_rvalid = (state == RD_RET) && (rd_owner == OWN_IF);
  assign ls_rvalid = (state == RD_RET) && (rd_owner == OWN_LS);
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;

endmodule

// File: tb/tb_progmem_arbiter.sv
// Directed bench for progmem_arbiter with a byte-maskable memory model.
module tb_progmem_arbiter;
  import progmem_arbiter_pkg::*;

  localparam int unsigned ADDR_W = 32;

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              ls_req;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic [3:0]        ls_wmask;
  logic              ls_ready;
  logic              ls_rvalid;
  logic [31:0]       ls_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_rd;
  logic [3:0]        mem_wr;
  logic [31:0]       mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:63];

  progmem_arbiter #(
    .ADDR_W     (ADDR_W),
    .MAX_STREAK (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_wmask  (ls_wmask),
    .ls_ready  (ls_ready),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'h0A0A_0001;
      1:       return 32'h0B0B_0002;
      2:       return 32'h0C0C_0003;
      4:       return 32'hDEAD_BEEF;
      8:       return 32'hAABB_CCDD;
      default: return 32'h1000_0000 | 32'(i);
    endcase
  endfunction

  // Memory model: registered read data, byte-masked writes, reloaded in reset.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      mem_rdata <= '0;
    end else begin
      if (mem_rd) mem_rdata <= mem[mem_addr[7:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wr[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic idle_inputs();
    if_req   = 1'b0;
    if_addr  = '0;
    ls_req   = 1'b0;
    ls_addr  = '0;
    ls_wdata = '0;
    ls_wmask = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    if_req = 1'b1; if_addr = 32'h10;
    ls_req = 1'b1; ls_addr = 32'h20; ls_wmask = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (if_ready !== 1'b0) begin errors++; $display("FAIL reset_if_ready: got %b exp 0", if_ready); end
    checks++; if (ls_ready !== 1'b0) begin errors++; $display("FAIL reset_ls_ready: got %b exp 0", ls_ready); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b exp 0", mem_rd); end
    checks++; if (mem_wr !== 4'h0) begin errors++; $display("FAIL reset_mem_wr: got %h exp 0", mem_wr); end
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL reset_if_rvalid: got %b exp 0", if_rvalid); end
    checks++; if (ls_rvalid !== 1'b0) begin errors++; $display("FAIL reset_ls_rvalid: got %b exp 0", ls_rvalid); end
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
  endtask

  task automatic test_idle();
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL idle_mem_rd: got %b exp 0", mem_rd); end
    checks++; if (mem_wr !== 4'h0) begin errors++; $display("FAIL idle_mem_wr: got %h exp 0", mem_wr); end
    checks++; if ({if_ready, ls_ready} !== 2'b00) begin errors++; $display("FAIL idle_ready: got %b exp 00", {if_ready, ls_ready}); end
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h10;
    #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL fetch_ready: got %b exp 1", if_ready); end
    checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL fetch_mem_rd: got %b exp 1", mem_rd); end
    checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL fetch_mem_addr: got %h exp 00000010", mem_addr); end
    checks++; if (mem_wr !== 4'h0) begin errors++; $display("FAIL fetch_mem_wr: got %h exp 0", mem_wr); end
    repeat (RD_LATENCY) @(negedge clk);
    if_req = 1'b0;
    #1;
    checks++; if (if_rvalid !== 1'b1) begin errors++; $display("FAIL fetch_rvalid: got %b exp 1", if_rvalid); end
    checks++; if (if_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fetch_rdata: got %h exp deadbeef", if_rdata); end
    checks++; if (ls_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_ls_rvalid: got %b exp 0", ls_rvalid); end
    @(negedge clk);
    #1;
    checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_rvalid_drop: got %b exp 0", if_rvalid); end
  endtask

  task automatic test_contention();
    logic [0:6] exp_ls;
    exp_ls = 7'b1111011;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h44;
    ls_req = 1'b1; ls_addr = 32'h40; ls_wmask = 4'h0;
    for (int i = 0; i < 7; i++) begin
      #1;
      checks++; if (ls_ready !== exp_ls[i] || if_ready !== !exp_ls[i]) begin
        errors++; $display("FAIL contention_grant[%0d]: got ls=%b if=%b exp ls=%b", i, ls_ready, if_ready, exp_ls[i]);
      end
      if (i > 0) begin
        checks++; if (ls_rvalid !== exp_ls[i-1] || if_rvalid !== !exp_ls[i-1]) begin
          errors++; $display("FAIL contention_rvalid[%0d]: got ls=%b if=%b exp ls=%b", i, ls_rvalid, if_rvalid, exp_ls[i-1]);
        end
        checks++; if ((exp_ls[i-1] ? ls_rdata : if_rdata) !== (exp_ls[i-1] ? 32'h1000_0010 : 32'h1000_0011)) begin
          errors++; $display("FAIL contention_rdata[%0d]: got ls=%h if=%h", i, ls_rdata, if_rdata);
        end
      end
      @(negedge clk);
    end
    idle_inputs();
    #1;
    checks++; if (ls_rvalid !== 1'b1 || ls_rdata !== 32'h1000_0010) begin
      errors++; $display("FAIL contention_last: got rvalid=%b data=%h exp 1 10000010", ls_rvalid, ls_rdata);
    end
  endtask

  task automatic test_write_readback();
    @(negedge clk);
    ls_req = 1'b1; ls_addr = 32'h20; ls_wmask = 4'b0101; ls_wdata = 32'h1122_3344;
    #1;
    checks++; if (ls_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b exp 1", ls_ready); end
    checks++; if (mem_wr !== 4'b0101) begin errors++; $display("FAIL wr_mem_wr: got %b exp 0101", mem_wr); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL wr_mem_rd: got %b exp 0", mem_rd); end
    checks++; if (mem_wdata !== 32'h1122_3344 || mem_addr !== 32'h20) begin
      errors++; $display("FAIL wr_mem_bus: got addr=%h data=%h exp 00000020 11223344", mem_addr, mem_wdata);
    end
    @(negedge clk);
    ls_wmask = 4'h0;
    #1;
    checks++; if ({if_rvalid, ls_rvalid} !== 2'b00) begin errors++; $display("FAIL wr_no_rvalid: got %b exp 00", {if_rvalid, ls_rvalid}); end
    checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL rb_mem_rd: got %b exp 1", mem_rd); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (ls_rvalid !== 1'b1) begin errors++; $display("FAIL rb_rvalid: got %b exp 1", ls_rvalid); end
    checks++; if (ls_rdata !== 32'hAA22_CC44) begin errors++; $display("FAIL rb_rdata: got %h exp aa22cc44", ls_rdata); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0;
    #1;
    checks++; if (if_ready !== 1'b1) begin errors++; $display("FAIL b2b_if_ready: got %b exp 1", if_ready); end
    @(negedge clk);
    if_req = 1'b0; ls_req = 1'b1; ls_addr = 32'h4;
    #1;
    checks++; if (ls_ready !== 1'b1) begin errors++; $display("FAIL b2b_ls_ready: got %b exp 1", ls_ready); end
    checks++; if (if_rvalid !== 1'b1 || ls_rvalid !== 1'b0 || if_rdata !== 32'h0A0A_0001) begin
      errors++; $display("FAIL b2b_ret0: got if=%b ls=%b data=%h exp 1 0 0a0a0001", if_rvalid, ls_rvalid, if_rdata);
    end
    @(negedge clk);
    ls_req = 1'b0; if_req = 1'b1; if_addr = 32'h8;
    #1;
    checks++; if (ls_rvalid !== 1'b1 || if_rvalid !== 1'b0 || ls_rdata !== 32'h0B0B_0002) begin
      errors++; $display("FAIL b2b_ret1: got ls=%b if=%b data=%h exp 1 0 0b0b0002", ls_rvalid, if_rvalid, ls_rdata);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (if_rvalid !== 1'b1 || ls_rvalid !== 1'b0 || if_rdata !== 32'h0C0C_0003) begin
      errors++; $display("FAIL b2b_ret2: got if=%b ls=%b data=%h exp 1 0 0c0c0003", if_rvalid, ls_rvalid, if_rdata);
    end
  endtask

  task automatic test_write_only_streak();
    @(negedge clk);
    ls_req = 1'b1; ls_addr = 32'h30; ls_wmask = 4'hF; ls_wdata = 32'h5555_5555;
    #1;
    checks++; if (mem_wr !== 4'hF) begin errors++; $display("FAIL wonly_mem_wr: got %h exp f", mem_wr); end
    repeat (6) @(negedge clk);
    ls_wmask = 4'h0; ls_addr = 32'h40;
    if_req = 1'b1; if_addr = 32'h44;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (ls_ready !== (i < 4) || if_ready !== (i == 4)) begin
        errors++; $display("FAIL wonly_grant[%0d]: got ls=%b if=%b exp ls=%b", i, ls_ready, if_ready, (i < 4));
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    logic [0:4] exp_ls;
    exp_ls = 5'b11110;
    @(negedge clk);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h44;
    ls_req = 1'b1; ls_addr = 32'h40;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if ({if_rvalid, ls_rvalid} !== 2'b00) begin errors++; $display("FAIL mid_rvalid: got %b exp 00", {if_rvalid, ls_rvalid}); end
    checks++; if ({if_ready, ls_ready, mem_rd} !== 3'b000 || mem_wr !== 4'h0) begin
      errors++; $display("FAIL mid_outputs: got ready/rd=%b wr=%h exp 000 0", {if_ready, ls_ready, mem_rd}, mem_wr);
    end
    @(negedge clk);
    #1;
    checks++; if ({if_rvalid, ls_rvalid} !== 2'b00) begin errors++; $display("FAIL mid_rvalid_hold: got %b exp 00", {if_rvalid, ls_rvalid}); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({if_rvalid, ls_rvalid} !== 2'b00) begin errors++; $display("FAIL mid_release_rvalid: got %b exp 00", {if_rvalid, ls_rvalid}); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) #1;
      checks++; if (ls_ready !== exp_ls[i] || if_ready !== !exp_ls[i]) begin
        errors++; $display("FAIL mid_grant[%0d]: got ls=%b if=%b exp ls=%b", i, ls_ready, if_ready, exp_ls[i]);
      end
      @(negedge clk);
    end
    idle_inputs();
    #1;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h1000_0011) begin
      errors++; $display("FAIL mid_final_ret: got rvalid=%b data=%h exp 1 10000011", if_rvalid, if_rdata);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_idle();
    test_single_fetch();
    test_contention();
    test_write_readback();
    test_back_to_back();
    test_write_only_streak();
    test_reset_mid_read();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish by 50000 exp finish");
    $fatal(1);
  end

endmodule
